lif_chain: RTL and testbench
============================

# lif_chain

Parametrised chain of leaky integrate-and-fire (LIF) neuron stages, intended as the next-generation core of the Tiny Tapeout neuron-chain designs. Each stage integrates a synaptic input into a saturating membrane potential, applies a programmable shift leak, fires on threshold, and observes a refractory period. Stages feed forward in one of two modes: membrane-potential pass-through, or weighted spike. The block sits between the `tt_um_*` wrapper pins (`ui_in`/`uo_out`) and the chain, and is fully synchronous.

## Interface
Parameters:
- `NUM_STAGES`, 7: number of chained LIF stages; legal range 1..16.
- `WIDTH`, 8: membrane/input width in bits; legal range 4..16.
- `CNT_WIDTH`, 16: width of the last-stage spike counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  global enable; when low, all state holds.
- `i_syn`  in  WIDTH  synaptic input to stage 0, unsigned.
- `threshold`  in  WIDTH  firing threshold shared by all stages; 0 disables firing.
- `leak_shift`  in  4  leak = V >> leak_shift; 0 means no leak.
- `refr_cycles`  in  4  refractory length in enabled cycles after a spike.
- `mode`  in  1  0 = pass V_k to stage k+1; 1 = pass (spike_k ? weight : 0).
- `weight`  in  WIDTH  synaptic weight used in mode 1.
- `v_out`  out  WIDTH  membrane potential of the last stage.
- `spikes`  out  NUM_STAGES  registered spike flag per stage; bit k = stage k.
- `spike_count`  out  CNT_WIDTH  saturating count of last-stage spikes.

## Operation
- Stage k input: stage 0 uses `i_syn`; stage k>0 uses registered V_{k-1} (mode 0) or `spikes[k-1] ? weight : 0` (mode 1).
- Per enabled edge, stage k, if refractory counter R_k = 0:
  - `sum = V + I - (leak_shift==0 ? 0 : V >> leak_shift)`, computed in WIDTH+1 bits, never negative (the subtracted leak ≤ V).
  - If `threshold != 0` and `sum >= threshold`: `spikes[k] <= 1`, `V <= 0`, `R_k <= refr_cycles`.
  - Else: `spikes[k] <= 0`, `V <= min(sum, 2^WIDTH-1)`.
- If R_k != 0: `V <= 0`, `spikes[k] <= 0`, `R_k <= R_k-1`, input ignored.
- `spike_count` increments on each edge where the last stage fires; it holds at 2^CNT_WIDTH-1.
- `en` low: V, R, spikes and count all hold; inputs are ignored.
- `mode`, `threshold` and `leak_shift` may change on any cycle; the new value applies from the next edge, with no flush.
- Reset values: all V = 0, all R = 0, `spikes` = 0, `spike_count` = 0, `v_out` = 0.

## Timing
- All outputs are registered; no combinational path from input to output.
- Stage latency is 1 cycle; `i_syn` reaches stage k's potential after k+1 enabled edges.
- Spike and V-reset occur on the same edge; the downstream stage sees the spike on the following edge.
- `rst` takes priority over `en`. Reset mid-spike or mid-refractory clears everything on that edge.
- The saturation clamp is applied before the threshold compare result is used for V. A saturated sum still fires if `threshold != 0`.

## Structure
- Package `lif_pkg`: `MODE_VPASS`/`MODE_SPIKE` constants, and the default `WIDTH`/`NUM_STAGES`.
- Sub-module `lif_stage`: one neuron (V register, refractory counter, leak/saturate/compare). It is instantiated with a generate loop. The top level holds the inter-stage mux and `spike_count`.

## Test plan
(All scenarios: `NUM_STAGES`=2, `WIDTH`=8.)
- Integrate/fire: `i_syn`=30, `threshold`=100, `leak_shift`=0, `refr_cycles`=0, `mode`=1, `weight`=50.
  - Stage-0 V = 30, 60, 90, then spike with V=0.
  - `spikes[0]` pulses every 4th edge.
  - Stage 1 gains 50 per spike and fires on its 2nd spike input.
- Refractory: same as above with `refr_cycles`=2. Stage-0 V sequence is 30, 60, 90, spike, 0, 0, 30…; period 6.
- Leak: `i_syn`=10, `threshold`=0, `leak_shift`=1. Stage-0 V = 10, 15, 18, 19, 20, 20 (steady); `spikes` stays 0.
- Saturation/mode 0: `i_syn`=255, `threshold`=0, `leak_shift`=0, `mode`=0.
  - Stage-0 V = 255 after edge 1 and stays there.
  - Stage-1 V = 0, 255, 255.
  - `v_out` = 255 from edge 2.
- Enable/reset: freeze with `en`=0 mid-integration (V=60); V holds for 5 cycles, then resumes at 90. Then assert `rst` during refractory → all outputs 0 on the next edge.
- Counter saturation: with `CNT_WIDTH`=4 and continuous last-stage firing, `spike_count` reaches 15 and holds.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared constants for the leaky integrate-and-fire neuron chain.
package lif_pkg;

    // Inter-stage feed-forward selection
    localparam logic MODE_VPASS = 1'b0;   // stage k+1 integrates V_k
    localparam logic MODE_SPIKE = 1'b1;   // stage k+1 integrates weight on spike_k

    // Default geometry
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_NUM_STAGES = 7;
    localparam int DEF_CNT_WIDTH  = 16;

endpackage : lif_pkg

// File: rtl/lif_stage.sv
// One LIF neuron: membrane register, refractory counter, shift leak,
// saturating integration and threshold compare. The spike flag itself is
// registered by the parent so all flags live in one vector.
module lif_stage
    import lif_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] syn_in,
    input  logic [WIDTH-1:0] threshold,
    input  logic [3:0]       leak_shift,
    input  logic [3:0]       refr_cycles,
    output logic [WIDTH-1:0] v,
    output logic             fire
);

    localparam logic [WIDTH:0] V_MAX_C = {1'b0, {WIDTH{1'b1}}};

    logic [WIDTH-1:0] v_r;
    logic [3:0]       refr_r;
    logic [WIDTH:0]   leak_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] v_clamp_s;
    logic             fire_s;

    // Leak, integration (one extra bit of headroom), clamp and fire decision
    always_comb begin
        leak_s    = {(WIDTH+1){1'b0}};
        sum_s     = {(WIDTH+1){1'b0}};
        v_clamp_s = {WIDTH{1'b0}};
        fire_s    = 1'b0;
        if (leak_shift != 4'd0) begin
            leak_s = {1'b0, (v_r >> leak_shift)};
        end else begin
            leak_s = {(WIDTH+1){1'b0}};
        end
        // leak never exceeds V, so the difference cannot go negative
        sum_s = {1'b0, v_r} + {1'b0, syn_in} - leak_s;
        if (sum_s > V_MAX_C) begin
            v_clamp_s = V_MAX_C[WIDTH-1:0];
        end else begin
            v_clamp_s = sum_s[WIDTH-1:0];
        end
        if ((refr_r == 4'd0) && (threshold != {WIDTH{1'b0}}) &&
            (sum_s >= {1'b0, threshold})) begin
            fire_s = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
    end

    // Membrane potential and refractory counter update
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r    <= {WIDTH{1'b0}};
            refr_r <= 4'd0;
        end else if (en) begin
            if (refr_r != 4'd0) begin
                v_r    <= {WIDTH{1'b0}};
                refr_r <= refr_r - 4'd1;
            end else if (fire_s) begin
                v_r    <= {WIDTH{1'b0}};
                refr_r <= refr_cycles;
            end else begin
                v_r    <= v_clamp_s;
                refr_r <= 4'd0;
            end
        end else begin
            v_r    <= v_r;
            refr_r <= refr_r;
        end
    end

    assign v    = v_r;
    assign fire = fire_s;

endmodule : lif_stage

// File: rtl/lif_chain.sv
// Chain of LIF stages with selectable feed-forward (membrane pass-through or
// weighted spike), per-stage registered spike flags and a saturating spike
// counter on the last stage.
module lif_chain
    import lif_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WIDTH-1:0]      i_syn,
    input  logic [WIDTH-1:0]      threshold,
    input  logic [3:0]            leak_shift,
    input  logic [3:0]            refr_cycles,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      weight,
    output logic [WIDTH-1:0]      v_out,
    output logic [NUM_STAGES-1:0] spikes,
    output logic [CNT_WIDTH-1:0]  spike_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX_C = {CNT_WIDTH{1'b1}};

    logic [WIDTH-1:0]      stage_in_s [NUM_STAGES];
    logic [WIDTH-1:0]      stage_v_s  [NUM_STAGES];
    logic [NUM_STAGES-1:0] fire_s;
    logic [NUM_STAGES-1:0] spikes_r;
    logic [CNT_WIDTH-1:0]  count_r;

    genvar k;
    generate
        for (k = 0; k < NUM_STAGES; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign stage_in_s[k] = i_syn;
            end else begin : g_next
                // Upstream values are registered, so this mux never chains
                // combinationally across stages.
                assign stage_in_s[k] = (mode == MODE_SPIKE)
                                     ? (spikes_r[k-1] ? weight : {WIDTH{1'b0}})
                                     : stage_v_s[k-1];
            end

            lif_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk         (clk),
                .rst         (rst),
                .en          (en),
                .syn_in      (stage_in_s[k]),
                .threshold   (threshold),
                .leak_shift  (leak_shift),
                .refr_cycles (refr_cycles),
                .v           (stage_v_s[k]),
                .fire        (fire_s[k])
            );
        end
    endgenerate

    // Registered spike flags, one per stage
    always_ff @(posedge clk) begin
        if (rst) begin
            spikes_r <= {NUM_STAGES{1'b0}};
        end else if (en) begin
            spikes_r <= fire_s;
        end else begin
            spikes_r <= spikes_r;
        end
    end

    // Saturating count of last-stage firings, counted on the firing edge
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (en && fire_s[NUM_STAGES-1] && (count_r != CNT_MAX_C)) begin
            count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign v_out       = stage_v_s[NUM_STAGES-1];
    assign spikes      = spikes_r;
    assign spike_count = count_r;

endmodule : lif_chain

// File: tb/tb_lif_chain.sv
// Self-checking bench for lif_chain: directed scenarios followed by random
// stimulus, all compared against an integer reference model of the neuron
// rules.
module tb_lif_chain;

    localparam int NS = 2;
    localparam int W  = 8;
    localparam int CW = 4;
    localparam int VMAX = (1 << W) - 1;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          en;
    logic [W-1:0]  i_syn;
    logic [W-1:0]  threshold;
    logic [3:0]    leak_shift;
    logic [3:0]    refr_cycles;
    logic          mode;
    logic [W-1:0]  weight;
    logic [W-1:0]  v_out;
    logic [NS-1:0] spikes;
    logic [CW-1:0] spike_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    int mv  [NS];
    int mr  [NS];
    int msp [NS];
    int mcnt;

    lif_chain #(
        .NUM_STAGES (NS),
        .WIDTH      (W),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .i_syn       (i_syn),
        .threshold   (threshold),
        .leak_shift  (leak_shift),
        .refr_cycles (refr_cycles),
        .mode        (mode),
        .weight      (weight),
        .v_out       (v_out),
        .spikes      (spikes),
        .spike_count (spike_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one clock edge of the neuron rules to the model
    task automatic model_edge();
        int nv [NS];
        int nr [NS];
        int ns [NS];
        int in_k, leak, sum;
        if (rst) begin
            for (int k = 0; k < NS; k++) begin
                mv[k] = 0; mr[k] = 0; msp[k] = 0;
            end
            mcnt = 0;
        end else if (en) begin
            for (int k = 0; k < NS; k++) begin
                if (k == 0)        in_k = int'(i_syn);
                else if (mode == 1'b0) in_k = mv[k-1];
                else               in_k = (msp[k-1] != 0) ? int'(weight) : 0;
                if (mr[k] != 0) begin
                    nv[k] = 0; ns[k] = 0; nr[k] = mr[k] - 1;
                end else begin
                    leak = (leak_shift == 4'd0) ? 0 : (mv[k] >> leak_shift);
                    sum  = mv[k] + in_k - leak;
                    if (threshold != 0 && sum >= int'(threshold)) begin
                        nv[k] = 0; ns[k] = 1; nr[k] = int'(refr_cycles);
                    end else begin
                        nv[k] = (sum > VMAX) ? VMAX : sum; ns[k] = 0; nr[k] = 0;
                    end
                end
            end
            if (ns[NS-1] != 0 && mcnt < CMAX) mcnt++;
            for (int k = 0; k < NS; k++) begin
                mv[k] = nv[k]; mr[k] = nr[k]; msp[k] = ns[k];
            end
        end
    endtask

    task automatic compare_all();
        int sp;
        sp = 0;
        for (int k = 0; k < NS; k++) sp |= (msp[k] << k);
        check("v_out", 32'(v_out), 32'(mv[NS-1]));
        check("spikes", 32'(spikes), 32'(sp));
        check("spike_count", 32'(spike_count), 32'(mcnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; i_syn = 8'd0; threshold = 8'd0;
        leak_shift = 4'd0; refr_cycles = 4'd0; mode = 1'b0; weight = 8'd0;
        for (int k = 0; k < NS; k++) begin mv[k] = 0; mr[k] = 0; msp[k] = 0; end
        mcnt = 0;

        // reset state
        step();
        check("reset_v_out", 32'(v_out), 32'd0);
        check("reset_spikes", 32'(spikes), 32'd0);
        check("reset_count", 32'(spike_count), 32'd0);
        rst = 1'b0;

        // integrate and fire, weighted spike mode
        i_syn = 8'd30; threshold = 8'd100; leak_shift = 4'd0;
        refr_cycles = 4'd0; mode = 1'b1; weight = 8'd50;
        do_reset();
        steps(4);
        check("if_spike0_edge4", 32'(spikes), 32'd1);
        steps(4);
        check("if_v1_after_one_spike", 32'(v_out), 32'd50);
        step();
        check("if_spike1_edge9", 32'(spikes), 32'd2);
        check("if_count_edge9", 32'(spike_count), 32'd1);

        // refractory period of two cycles gives period 6
        refr_cycles = 4'd2;
        do_reset();
        steps(4);
        check("refr_first_spike", 32'(spikes[0]), 32'd1);
        steps(5);
        check("refr_no_early_spike", 32'(spikes[0]), 32'd0);
        step();
        check("refr_second_spike", 32'(spikes[0]), 32'd1);

        // shift leak, firing disabled
        i_syn = 8'd10; threshold = 8'd0; leak_shift = 4'd1;
        refr_cycles = 4'd0; mode = 1'b0;
        do_reset();
        steps(12);
        check("leak_no_spikes", 32'(spikes), 32'd0);

        // saturation in pass-through mode
        i_syn = 8'd255; threshold = 8'd0; leak_shift = 4'd0; mode = 1'b0;
        do_reset();
        step();
        check("sat_v1_edge1", 32'(v_out), 32'd0);
        step();
        check("sat_v1_edge2", 32'(v_out), 32'd255);
        steps(3);
        check("sat_v1_hold", 32'(v_out), 32'd255);

        // freeze mid-integration, then reset during refractory
        i_syn = 8'd30; threshold = 8'd100; leak_shift = 4'd0;
        refr_cycles = 4'd3; mode = 1'b1; weight = 8'd50;
        do_reset();
        steps(2);
        en = 1'b0;
        steps(5);
        check("freeze_spikes", 32'(spikes), 32'd0);
        en = 1'b1;
        step();
        step();
        check("resume_fire", 32'(spikes[0]), 32'd1);
        step();
        rst = 1'b1;
        step();
        check("rst_refr_v_out", 32'(v_out), 32'd0);
        check("rst_refr_spikes", 32'(spikes), 32'd0);
        check("rst_refr_count", 32'(spike_count), 32'd0);
        rst = 1'b0;

        // counter saturation with the last stage firing every edge
        i_syn = 8'd255; threshold = 8'd1; refr_cycles = 4'd0;
        mode = 1'b1; weight = 8'd255;
        do_reset();
        steps(20);
        check("count_saturated", 32'(spike_count), 32'd15);
        steps(3);
        check("count_holds", 32'(spike_count), 32'd15);

        // random stimulus
        do_reset();
        for (int n = 0; n < 600; n++) begin
            i_syn       = 8'($urandom_range(0, 255));
            threshold   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            leak_shift  = 4'($urandom_range(0, 9));
            refr_cycles = 4'($urandom_range(0, 4));
            mode        = 1'($urandom_range(0, 1));
            weight      = 8'($urandom_range(0, 255));
            en          = ($urandom_range(0, 9) != 0);
            rst         = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; en = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_lif_chain
